// File: rtl/snacks_pkg.sv
// Shared types and default widths for the instruction-fetch slice.
package snacks_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    localparam int IW_DEF = 16;
    localparam int DW_DEF = 9;
    localparam int OW_DEF = 8;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/inst_fetch_if.sv
// Control, branch, ROM and decode-side signals of the fetch unit.
// The fetch unit takes the master view; the core/ROM environment takes slave.
interface inst_fetch_if
    import snacks_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF,
    parameter int CW = CW_DEF
) ();

    logic          Start;
    logic [IW-1:0] StartAddr;
    logic          Stall;
    logic          Halt;
    logic          BranchAbs;
    logic          BranchRel;
    logic [IW-1:0] Target;
    logic [OW-1:0] Offset;
    logic [DW-1:0] InstIn;
    logic [IW-1:0] InstAddress;
    logic [DW-1:0] Inst;
    logic          InstValid;
    logic          Done;
    logic          Overflow;
    logic [CW-1:0] InstCount;

    modport master (
        input  Start, StartAddr, Stall, Halt, BranchAbs, BranchRel,
               Target, Offset, InstIn,
        output InstAddress, Inst, InstValid, Done, Overflow, InstCount
    );

    modport slave (
        output Start, StartAddr, Stall, Halt, BranchAbs, BranchRel,
               Target, Offset, InstIn,
        input  InstAddress, Inst, InstValid, Done, Overflow, InstCount
    );

endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: hold, absolute target, relative add or
// increment, with a wrap flag for the two arithmetic paths.
module fetch_pc_next #(
    parameter int IW = 16,
    parameter int OW = 8
) (
    input  logic [IW-1:0] pc,
    input  logic          hold,
    input  logic          branch_abs,
    input  logic          branch_rel,
    input  logic [IW-1:0] target,
    input  logic [OW-1:0] offset,
    output logic [IW-1:0] pc_next,
    output logic          wrap
);

    logic [IW-1:0] offset_sext;
    logic [IW:0]   inc_sum;
    logic [IW:0]   rel_sum;

    assign offset_sext = IW'($signed(offset));
    assign inc_sum     = {1'b0, pc} + (IW+1)'(1);
    assign rel_sum     = {1'b0, pc} + {1'b0, offset_sext};

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_next = pc;
        wrap    = 1'b0;
        if (hold) begin
            pc_next = pc;
        end else if (branch_abs) begin
            pc_next = target;
        end else if (branch_rel) begin
            pc_next = rel_sum[IW-1:0];
            // Negative offsets wrap on borrow, i.e. when the add does not carry.
            wrap    = offset[OW-1] ? ~rel_sum[IW] : rel_sum[IW];
        end else begin
            pc_next = inc_sum[IW-1:0];
            wrap    = inc_sum[IW];
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, addresses the combinational ROM, registers
// the returned word for decode, and counts issued instructions.
module inst_fetch
    import snacks_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF,
    parameter int OW = OW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic CLK,
    input  logic Reset,
    inst_fetch_if.master bus
);

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d, pc_next;
    logic [DW-1:0] inst_q, inst_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrap;

    fetch_pc_next #(.IW(IW), .OW(OW)) u_pc_next (
        .pc         (pc_q),
        .hold       (bus.Halt | bus.Stall),
        .branch_abs (bus.BranchAbs),
        .branch_rel (bus.BranchRel),
        .target     (bus.Target),
        .offset     (bus.Offset),
        .pc_next    (pc_next),
        .wrap       (wrap)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        count_d = (valid_q && count_q != '1) ? count_q + CW'(1) : count_q;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = bus.StartAddr;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    state_d = HALTED;
                end else if (!bus.Stall) begin
                    // InstIn is only captured here, so ROM X outside RUN never reaches Inst.
                    pc_d    = pc_next;
                    inst_d  = bus.InstIn;
                    valid_d = 1'b1;
                    ovf_d   = ovf_q | wrap;
                end
            end
            HALTED: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = bus.StartAddr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.Inst        = inst_q;
    assign bus.InstValid   = valid_q;
    assign bus.Done        = (state_q == HALTED);
    assign bus.Overflow    = ovf_q;
    assign bus.InstCount   = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised and directed check of inst_fetch against a cycle-level model
// built from the fetch rules with plain integer arithmetic.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    inst_fetch_if #(.IW(16), .DW(9), .OW(8), .CW(16)) bus ();

    inst_fetch #(.IW(16), .DW(9), .OW(8), .CW(16)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    function automatic logic [8:0] rom(input logic [15:0] a);
        logic [31:0] v;
        v = (32'(a) * 32'd37) ^ (32'(a) >> 7);
        return v[8:0];
    endfunction

    assign bus.InstIn = rom(bus.InstAddress);

    // Reference model state
    bit          m_running, m_halted;
    logic [15:0] m_pc;
    logic [8:0]  m_inst;
    bit          m_valid, m_ovf;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int nxt;
        int new_count;
        new_count = m_valid ? ((m_count < 65535) ? m_count + 1 : 65535) : m_count;
        if (rst) begin
            m_running = 0; m_halted = 0; m_pc = 16'h0; m_inst = 9'h0;
            m_valid = 0; m_ovf = 0; new_count = 0;
        end else if (m_running) begin
            if (bus.Halt) begin
                m_running = 0; m_halted = 1; m_valid = 0;
            end else if (bus.Stall) begin
                m_valid = 0;
            end else begin
                m_inst  = rom(m_pc);
                m_valid = 1;
                if (bus.BranchAbs)      nxt = int'(bus.Target);
                else if (bus.BranchRel) nxt = int'(m_pc) + int'($signed(bus.Offset));
                else                    nxt = int'(m_pc) + 1;
                if (nxt < 0 || nxt > 65535) m_ovf = 1;
                m_pc = 16'(nxt);
            end
        end else begin
            m_valid = 0;
            if (bus.Start) begin
                m_running = 1; m_halted = 0; m_pc = bus.StartAddr;
            end else if (!m_halted) begin
                m_pc = 16'h0;
            end
        end
        m_count = new_count;
    endtask

    task automatic compare_all();
        check("addr",     32'(bus.InstAddress), 32'(m_pc));
        check("inst",     32'(bus.Inst),        32'(m_inst));
        check("valid",    32'(bus.InstValid),   32'(m_valid));
        check("done",     32'(bus.Done),        32'(m_halted));
        check("overflow", 32'(bus.Overflow),    32'(m_ovf));
        check("count",    32'(bus.InstCount),   32'(m_count));
    endtask

    task automatic clear_inputs();
        rst = 0;
        bus.Start = 0; bus.StartAddr = 16'h0; bus.Stall = 0; bus.Halt = 0;
        bus.BranchAbs = 0; bus.BranchRel = 0; bus.Target = 16'h0; bus.Offset = 8'h0;
    endtask

    task automatic tick(input bit do_check);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) compare_all();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #2;
        rst = 1; tick(1);
        rst = 1; tick(1);
        check("reset_addr", 32'(bus.InstAddress), 32'h0);

        // Sequential fetch from 0x0010
        bus.Start = 1; bus.StartAddr = 16'h0010; tick(1);
        check("start_addr", 32'(bus.InstAddress), 32'h0010);
        tick(1);
        check("seq_addr1", 32'(bus.InstAddress), 32'h0011);
        tick(1);
        check("seq_addr2", 32'(bus.InstAddress), 32'h0012);
        check("inst_lag", 32'(bus.Inst), 32'(rom(16'h0011)));

        // Absolute branch: old instruction still issued
        bus.BranchAbs = 1; bus.Target = 16'h0040; tick(1);
        check("babs_addr", 32'(bus.InstAddress), 32'h0040);
        check("babs_inst", 32'(bus.Inst), 32'(rom(16'h0012)));
        bus.BranchRel = 1; bus.Offset = 8'hFC; tick(1);
        check("brel_neg", 32'(bus.InstAddress), 32'h003C);
        check("count3", 32'(bus.InstCount), 32'd3);

        // Relative wrap sets sticky overflow
        bus.BranchAbs = 1; bus.Target = 16'hFFF0; tick(1);
        bus.BranchRel = 1; bus.Offset = 8'h7F; tick(1);
        check("brel_wrap", 32'(bus.InstAddress), 32'h006F);
        check("ovf_set", 32'(bus.Overflow), 32'h1);
        tick(1);
        check("ovf_sticky", 32'(bus.Overflow), 32'h1);

        // Stall holds PC; stall with branch drops the branch
        bus.BranchAbs = 1; bus.Target = 16'h0005; tick(1);
        bus.Stall = 1; tick(1);
        bus.Stall = 1; tick(1);
        check("stall_addr", 32'(bus.InstAddress), 32'h0005);
        check("stall_bubble", 32'(bus.InstValid), 32'h0);
        bus.Stall = 1; bus.BranchAbs = 1; bus.Target = 16'h0099; tick(1);
        check("stall_babs", 32'(bus.InstAddress), 32'h0005);
        tick(1);

        // Halt beats branch; restart from HALTED
        bus.BranchAbs = 1; bus.Target = 16'h0020; tick(1);
        bus.Halt = 1; bus.BranchAbs = 1; bus.Target = 16'h0077; tick(1);
        check("halt_done", 32'(bus.Done), 32'h1);
        check("halt_addr", 32'(bus.InstAddress), 32'h0020);
        tick(1);
        check("halt_frozen", 32'(bus.InstAddress), 32'h0020);
        bus.Start = 1; bus.StartAddr = 16'h0100; tick(1);
        check("restart_addr", 32'(bus.InstAddress), 32'h0100);
        check("restart_done", 32'(bus.Done), 32'h0);
        tick(1);
        bus.Start = 1; bus.StartAddr = 16'h0200; tick(1);
        check("start_in_run", 32'(bus.InstAddress), 32'h0102);

        // Reset mid-run
        bus.BranchAbs = 1; bus.Target = 16'h0033; tick(1);
        rst = 1; tick(1);
        check("rst_addr", 32'(bus.InstAddress), 32'h0);
        check("rst_ovf", 32'(bus.Overflow), 32'h0);
        check("rst_count", 32'(bus.InstCount), 32'h0);
        tick(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.Start     = ($urandom_range(0, 99) < 6);
            bus.StartAddr = ($urandom_range(0, 1) == 0) ? 16'(16'hFFE0 + $urandom_range(0, 31))
                                                        : 16'($urandom);
            bus.Halt      = ($urandom_range(0, 99) < 4);
            bus.Stall     = ($urandom_range(0, 99) < 12);
            bus.BranchAbs = ($urandom_range(0, 99) < 8);
            bus.BranchRel = ($urandom_range(0, 99) < 12);
            bus.Target    = 16'($urandom);
            bus.Offset    = 8'($urandom);
            rst           = ($urandom_range(0, 299) == 0);
            tick(1);
        end

        // Counter saturation over a long run
        rst = 1; tick(1);
        bus.Start = 1; bus.StartAddr = 16'h0000; tick(1);
        for (int i = 0; i < 65600; i++) tick((i % 1024) == 0);
        compare_all();
        check("count_sat", 32'(bus.InstCount), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch side of the instruction-memory interface: owns the program counter and drives InstAddress into the combinational instruction ROM.
- Registers the returned word, then presents it to decode with a valid flag.
- Supports start/halt control, stall, and absolute and relative branches.
- Sits between the core's control/branch logic and the instruction ROM.

Parameters:
- IW, 16, instruction address width (ROM depth 2**IW)
- DW, 9, instruction word width
- OW, 8, signed relative-branch offset width (OW <= IW)
- CW, 16, retired-instruction counter width

Ports:
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle pulse; begins fetching at StartAddr
- StartAddr  input  IW  first instruction address
- Stall  input  1  hold PC this cycle, issue bubble
- Halt  input  1  stop fetching, enter HALTED
- BranchAbs  input  1  next PC = Target
- BranchRel  input  1  next PC = PC + sign-extended Offset
- Target  input  IW  absolute branch target
- Offset  input  OW  two's-complement relative offset
- InstIn  input  DW  word returned by ROM for InstAddress (same cycle)
- InstAddress  output  IW  current PC, registered
- Inst  output  DW  latched instruction
- InstValid  output  1  Inst holds a new instruction this cycle
- Done  output  1  high while in HALTED
- Overflow  output  1  sticky: PC arithmetic wrapped past 2**IW
- InstCount  output  CW  count of cycles with InstValid=1, saturating

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; InstAddress=0, Inst=0, InstValid=0, Done=0, Overflow=0, InstCount=0.
  - Reset mid-RUN aborts immediately; the next cycle is IDLE.
- States:
  - IDLE: PC=0, InstValid=0.
    - Start -> RUN, PC<=StartAddr.
    - All other inputs ignored.
  - RUN: each edge, Inst<=InstIn (word at current PC).
    - Next-PC priority: Halt > Stall > BranchAbs > BranchRel > PC+1.
    - Halt: -> HALTED, PC held, InstValid<=0, Inst held.
    - Stall: PC held, InstValid<=0 (bubble), Inst held.
    - BranchAbs: PC<=Target, InstValid<=1.
    - BranchRel: PC<=(PC+sext(Offset)) mod 2**IW, InstValid<=1.
    - Otherwise: PC<=PC+1, InstValid<=1.
    - Start is ignored in RUN.
  - HALTED: Done=1, InstValid=0, PC frozen.
    - Start -> RUN with PC<=StartAddr, Done<=0 that edge.
- Latency:
  - InstAddress valid the cycle after the transition into RUN.
  - Inst/InstValid appear one cycle after InstAddress shows that address.
  - Branch decision at edge N gives the new InstAddress in cycle N+1 and its Inst in cycle N+2.
  - No flush: the instruction already latched at the branch edge is still issued.
- Arithmetic:
  - IW-bit modulo. Offset sign-extended to IW before the add.
  - Overflow<=1 when PC+1 carries out of IW bits, or a relative add wraps (unsigned carry for positive offset, borrow for negative).
  - Overflow is sticky until Reset; a Start does not clear it.
- InstCount: +1 on every cycle InstValid=1; holds at 2**CW-1.
- Simultaneous events:
  - Halt with BranchAbs/BranchRel/Stall: Halt wins, branch discarded.
  - Stall with a branch: branch discarded, not deferred.
  - BranchAbs and BranchRel together: BranchAbs wins.
- InstIn is sampled only in RUN; X on InstIn outside RUN must not propagate to Inst.

Decomposition:
- Shared package snacks_pkg:
  - fetch_state_t enum {IDLE, RUN, HALTED}
  - default width constants IW_DEF=16, DW_DEF=9.
- One natural sub-module: fetch_pc_next.
  - Combinational next-PC mux plus adder.
  - Inputs: PC, control flags, Target, Offset. Outputs: next PC and wrap flag.
- State register, Inst/InstValid, and counters stay in inst_fetch.

Test Plan:
- Reset, Start with StartAddr=0x0010, no control -> InstAddress 0x0010, 0x0011, 0x0012 on consecutive cycles; Inst one cycle behind; InstCount=3 after 3 valid cycles.
- BranchAbs Target=0x0040 while PC=0x0012 -> next InstAddress 0x0040; Inst for 0x0012 still issued; no bubble.
- BranchRel Offset=8'hFC (-4) at PC=0x0040 -> 0x003C. Offset=8'h7F at PC=0xFFF0 -> 0x006F with Overflow=1, sticky.
- Stall for 2 cycles at PC=0x0005 -> InstAddress held at 0x0005, InstValid=0 for 2 cycles, InstCount unchanged; Stall+BranchAbs same cycle -> branch ignored.
- Halt at PC=0x0020 with BranchAbs asserted -> HALTED, Done=1, PC frozen at 0x0020. Start with StartAddr=0x0100 -> RUN from 0x0100, Done=0, InstCount continues.
- Reset asserted mid-RUN at PC=0x0033 -> next cycle IDLE, all outputs 0; Start ignored in RUN; InstCount saturates at 0xFFFF in a long run (CW=16).
